// File: rtl/execute_stage_mc_if.sv
// DX -> EX -> XM bundle of the execute stage.
// The decode side drives the DX fields; the execute side returns the XM fields and stall.
interface execute_stage_mc_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  RD;
  logic [2:0]  ALUctr;
  logic [2:0]  DX_MemCtr;
  logic [31:0] RegtoMem;
  logic [2:0]  DX_BranchCtr;
  logic [31:0] DX_BranchAddr;

  logic [31:0] ALUout;
  logic [31:0] ALUoutBK;
  logic [4:0]  XM_RD;
  logic [2:0]  XM_MemCtr;
  logic [31:0] XM_RegtoMem;
  logic [2:0]  XM_BranchCtr;
  logic [31:0] XM_BranchAddr;
  logic        stall;

  modport master (
    output A, B, RD, ALUctr, DX_MemCtr, RegtoMem, DX_BranchCtr, DX_BranchAddr,
    input  ALUout, ALUoutBK, XM_RD, XM_MemCtr, XM_RegtoMem, XM_BranchCtr, XM_BranchAddr, stall
  );

  modport slave (
    input  A, B, RD, ALUctr, DX_MemCtr, RegtoMem, DX_BranchCtr, DX_BranchAddr,
    output ALUout, ALUoutBK, XM_RD, XM_MemCtr, XM_RegtoMem, XM_BranchCtr, XM_BranchAddr, stall
  );
endinterface

// File: rtl/execute_stage_mc.sv
// Execute stage: single-cycle ALU plus a 32-iteration restoring signed divider
// that stalls decode and emits bubbles until the HI/LO result is ready.
//
// state | meaning
// IDLE  | single-cycle ops; a nonzero DIV is latched here
// RUN   | one shift-subtract iteration per cycle, count 0..31
// DONE  | sign-fix and emit HI (remainder) / LO (quotient)
module execute_stage_mc #(
  parameter int         WIDTH     = 32,
  parameter logic [2:0] BUBBLE_MC = 3'd7,
  parameter logic [2:0] HILO_MC   = 3'd6
) (
  input logic               clk,
  input logic               rst,
  execute_stage_mc_if.slave dx
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd2;
  localparam logic [2:0] OP_BEQ = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_BNE = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       count_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic             sign_a_q, sign_b_q;
  logic [4:0]       rd_q;

  logic             div_start;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = (state_q == IDLE) && (dx.ALUctr == OP_DIV) && (dx.DX_MemCtr == HILO_MC);
    case (state_q)
      IDLE: if (div_start && (dx.B != '0)) state_d = RUN;
      RUN:  if (count_q == 5'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted so decode is never frozen by a dead divide.
  assign dx.stall = rst && ((div_start && (dx.B != '0)) || (state_q == RUN));

  always_comb begin
    alu_res = dx.A + dx.B;
    case (dx.ALUctr)
      OP_SUB, OP_BEQ, OP_BNE: alu_res = dx.A - dx.B;
      OP_SLT: alu_res = ($signed(dx.A) < $signed(dx.B)) ? 32'd1 : 32'd0;
      OP_XOR: alu_res = dx.A ^ dx.B;
      default: alu_res = dx.A + dx.B;
    endcase
  end

  assign abs_a   = dx.A[WIDTH-1] ? (~dx.A + 1'b1) : dx.A;
  assign abs_b   = dx.B[WIDTH-1] ? (~dx.B + 1'b1) : dx.B;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q          <= '0;
      rem_q            <= '0;
      quo_q            <= '0;
      div_q            <= '0;
      sign_a_q         <= 1'b0;
      sign_b_q         <= 1'b0;
      rd_q             <= '0;
      dx.ALUout        <= '0;
      dx.ALUoutBK      <= '0;
      dx.XM_RD         <= '0;
      dx.XM_MemCtr     <= '0;
      dx.XM_RegtoMem   <= '0;
      dx.XM_BranchCtr  <= '0;
      dx.XM_BranchAddr <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start && (dx.B == '0)) begin
            dx.ALUout        <= dx.A;
            dx.ALUoutBK      <= '1;
            dx.XM_RD         <= dx.RD;
            dx.XM_MemCtr     <= HILO_MC;
            dx.XM_RegtoMem   <= dx.RegtoMem;
            dx.XM_BranchCtr  <= '0;
            dx.XM_BranchAddr <= dx.DX_BranchAddr;
          end else if (div_start) begin
            rem_q            <= '0;
            quo_q            <= abs_a;
            div_q            <= abs_b;
            sign_a_q         <= dx.A[WIDTH-1];
            sign_b_q         <= dx.B[WIDTH-1];
            rd_q             <= dx.RD;
            count_q          <= '0;
            dx.ALUout        <= '0;
            dx.ALUoutBK      <= '0;
            dx.XM_RD         <= '0;
            dx.XM_MemCtr     <= BUBBLE_MC;
            dx.XM_RegtoMem   <= '0;
            dx.XM_BranchCtr  <= '0;
            dx.XM_BranchAddr <= '0;
          end else begin
            dx.ALUout        <= alu_res;
            dx.ALUoutBK      <= '0;
            dx.XM_RD         <= dx.RD;
            dx.XM_MemCtr     <= dx.DX_MemCtr;
            dx.XM_RegtoMem   <= dx.RegtoMem;
            dx.XM_BranchCtr  <= dx.DX_BranchCtr;
            dx.XM_BranchAddr <= dx.DX_BranchAddr;
          end
        end
        RUN: begin
          // shifted never exceeds 2*divisor-1, so its low WIDTH bits are lossless
          rem_q   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_q   <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          count_q <= count_q + 5'd1;
        end
        DONE: begin
          dx.ALUout        <= rem_fix;
          dx.ALUoutBK      <= quo_fix;
          dx.XM_RD         <= rd_q;
          dx.XM_MemCtr     <= HILO_MC;
          dx.XM_RegtoMem   <= '0;
          dx.XM_BranchCtr  <= '0;
          dx.XM_BranchAddr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Bench for execute_stage_mc: table of single-cycle ops, then divide,
// reset-abort and back-to-back sequences.
module tb_execute_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  execute_stage_mc_if dx ();
  execute_stage_mc dut (.clk(clk), .rst(rst), .dx(dx.slave));

  typedef struct {
    logic [2:0]  alu;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [2:0]  mc;
    logic [31:0] rtm;
    logic [2:0]  bc;
    logic [31:0] ba;
    logic [31:0] exp_out, exp_bk;
    logic [2:0]  exp_mc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [2:0] mc, input logic [31:0] rtm,
                        input logic [2:0] bc, input logic [31:0] ba);
    dx.ALUctr = alu; dx.A = a; dx.B = b; dx.RD = rd; dx.DX_MemCtr = mc;
    dx.RegtoMem = rtm; dx.DX_BranchCtr = bc; dx.DX_BranchAddr = ba;
  endtask

  // Emulates decode: DIV held on the DX bus until stall drops, then one more edge (E33).
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_q, input logic [31:0] exp_r);
    int n;
    set_in(3'd4, a, b, rd, 3'd6, 32'h0, 3'd0, 32'h0);
    #1;
    chk({nm, " stall at start"}, {31'b0, dx.stall}, 32'd1);
    n = 0;
    while (dx.stall && n < 100) begin
      n++;
      tick;
      if (n == 1) begin
        chk({nm, " bubble memctr"}, {29'b0, dx.XM_MemCtr}, 32'd7);
        chk({nm, " bubble rd"}, {27'b0, dx.XM_RD}, 32'd0);
        chk({nm, " bubble aluout"}, dx.ALUout, 32'd0);
      end
    end
    chk({nm, " stall cycles"}, n, 32'd33);
    tick;
    chk({nm, " rem"}, dx.ALUout, exp_r);
    chk({nm, " quot"}, dx.ALUoutBK, exp_q);
    chk({nm, " memctr"}, {29'b0, dx.XM_MemCtr}, 32'd6);
    chk({nm, " rd"}, {27'b0, dx.XM_RD}, {27'b0, rd});
    chk({nm, " brctr"}, {29'b0, dx.XM_BranchCtr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd5, 32'd7, 5'd3, 3'd1, 32'hAAAA5555, 3'd0, 32'h0, 32'd12, 32'd0, 3'd1};
    vecs[1]  = '{3'd1, 32'd5, 32'd7, 5'd4, 3'd2, 32'h00001234, 3'd0, 32'h0, 32'hFFFFFFFE, 32'd0, 3'd2};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'd1, 5'd5, 3'd0, 32'h0, 3'd0, 32'h0, 32'd1, 32'd0, 3'd0};
    vecs[3]  = '{3'd2, 32'd1, 32'hFFFFFFFF, 5'd6, 3'd0, 32'h0, 3'd0, 32'h0, 32'd0, 32'd0, 3'd0};
    vecs[4]  = '{3'd2, 32'h80000000, 32'h7FFFFFFF, 5'd7, 3'd0, 32'h0, 3'd0, 32'h0, 32'd1, 32'd0, 3'd0};
    vecs[5]  = '{3'd5, 32'hF0F0F0F0, 32'hFFFF0000, 5'd8, 3'd0, 32'h0, 3'd0, 32'h0, 32'h0F0FF0F0, 32'd0, 3'd0};
    vecs[6]  = '{3'd3, 32'd10, 32'd10, 5'd0, 3'd7, 32'h0, 3'd1, 32'h40, 32'd0, 32'd0, 3'd7};
    vecs[7]  = '{3'd6, 32'd9, 32'd3, 5'd0, 3'd7, 32'h0, 3'd1, 32'h80, 32'd6, 32'd0, 3'd7};
    vecs[8]  = '{3'd0, 32'h7FFFFFFF, 32'd1, 5'd9, 3'd0, 32'h0, 3'd0, 32'h0, 32'h80000000, 32'd0, 3'd0};
    vecs[9]  = '{3'd7, 32'd3, 32'd4, 5'd10, 3'd0, 32'h0, 3'd0, 32'h0, 32'd7, 32'd0, 3'd0};
    vecs[10] = '{3'd4, 32'd9, 32'd0, 5'd5, 3'd6, 32'h0, 3'd0, 32'h0, 32'd9, 32'hFFFFFFFF, 3'd6};
    vecs[11] = '{3'd0, 32'd0, 32'd0, 5'd11, 3'd3, 32'h0, 3'd2, 32'h1000, 32'd0, 32'd0, 3'd3};

    set_in(3'd0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0, 3'd0, 32'h0);
    #12;
    chk("reset aluout", dx.ALUout, 32'd0);
    chk("reset aluoutbk", dx.ALUoutBK, 32'd0);
    chk("reset memctr", {29'b0, dx.XM_MemCtr}, 32'd0);
    chk("reset rd", {27'b0, dx.XM_RD}, 32'd0);
    chk("reset stall", {31'b0, dx.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].alu, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].mc,
             vecs[i].rtm, vecs[i].bc, vecs[i].ba);
      #1;
      chk($sformatf("vec%0d stall", i), {31'b0, dx.stall}, 32'd0);
      tick;
      chk($sformatf("vec%0d aluout", i), dx.ALUout, vecs[i].exp_out);
      chk($sformatf("vec%0d aluoutbk", i), dx.ALUoutBK, vecs[i].exp_bk);
      chk($sformatf("vec%0d memctr", i), {29'b0, dx.XM_MemCtr}, {29'b0, vecs[i].exp_mc});
      chk($sformatf("vec%0d rd", i), {27'b0, dx.XM_RD}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d regtomem", i), dx.XM_RegtoMem, vecs[i].rtm);
      chk($sformatf("vec%0d brctr", i), {29'b0, dx.XM_BranchCtr}, {29'b0, vecs[i].bc});
      chk($sformatf("vec%0d braddr", i), dx.XM_BranchAddr, vecs[i].ba);
    end

    run_div("div 100/7", 32'd100, 32'd7, 5'd12, 32'd14, 32'd2);
    run_div("div -7/2", 32'hFFFFFFF9, 32'd2, 5'd13, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div min/-1", 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 32'd0);
    run_div("div 7/-100", 32'd7, 32'hFFFFFF9C, 5'd15, 32'd0, 32'd7);

    // DIV then BEQ: branch fields one cycle after the DIV result
    run_div("div before beq", 32'hFFFFFF9C, 32'd7, 5'd16, 32'hFFFFFFF2, 32'hFFFFFFFE);
    set_in(3'd3, 32'd10, 32'd10, 5'd0, 3'd7, 32'h0, 3'd1, 32'h40);
    tick;
    chk("beq after div brctr", {29'b0, dx.XM_BranchCtr}, 32'd1);
    chk("beq after div braddr", dx.XM_BranchAddr, 32'h40);
    chk("beq after div aluout", dx.ALUout, 32'd0);
    chk("beq after div aluoutbk", dx.ALUoutBK, 32'd0);
    chk("beq after div memctr", {29'b0, dx.XM_MemCtr}, 32'd7);

    // reset in the middle of a divide
    set_in(3'd4, 32'd100, 32'd7, 5'd17, 3'd6, 32'h0, 3'd0, 32'h0);
    repeat (10) tick;
    chk("mid-div stall", {31'b0, dx.stall}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort stall", {31'b0, dx.stall}, 32'd0);
    chk("abort aluout", dx.ALUout, 32'd0);
    chk("abort aluoutbk", dx.ALUoutBK, 32'd0);
    chk("abort memctr", {29'b0, dx.XM_MemCtr}, 32'd0);
    chk("abort rd", {27'b0, dx.XM_RD}, 32'd0);
    set_in(3'd0, 32'd1, 32'd1, 5'd18, 3'd0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-abort stall", {31'b0, dx.stall}, 32'd0);
    tick;
    chk("post-abort add", dx.ALUout, 32'd2);
    chk("post-abort rd", {27'b0, dx.XM_RD}, 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
